cricket_match_ctrl: RTL

- Match sequencer for the T20 game.
- Turns raw ball_sw presses and the 4-bit LFSR value into per-ball outcomes.
- Keeps score, wickets, balls and overs, and steps through innings 1, the innings break, innings 2 and game over.
- Sits between the board switches / LFSR and the display logic; owns every score register and the winner decision.

---
 rtl/cricket_match_ctrl.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/cricket_match_ctrl.sv
// T20 match sequencer: turns synchronised bowl presses and the LFSR value into
// per-ball outcomes, keeps score/wickets/balls/overs and decides the winner.
module cricket_match_ctrl #(
  parameter int unsigned BALLS_PER_OVER = 6,
  parameter int unsigned OVERS          = 20,
  parameter int unsigned MAX_WICKETS    = 10,
  parameter int unsigned RUN_W          = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ball_sw,
  input  logic             team_switch,
  input  logic [3:0]       lfsr_out,
  output logic             lfsr_step,
  output logic             ball_ack,
  output logic [RUN_W-1:0] runs,
  output logic [3:0]       wickets,
  output logic [2:0]       balls,
  output logic [4:0]       overs,
  output logic [RUN_W:0]   target,
  output logic             innings,
  output logic             inning_over,
  output logic             game_over,
  output logic             winner,
  output logic             tie
);

  typedef enum logic [1:0] {
    ST_INN1  = 2'd0,
    ST_BREAK = 2'd1,
    ST_INN2  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [2:0] LP_LAST_BALL = 3'(BALLS_PER_OVER - 1);
  localparam logic [4:0] LP_OVERS     = 5'(OVERS);
  localparam logic [3:0] LP_WICKETS   = 4'(MAX_WICKETS);

  state_t           r_state;
  logic [2:0]       r_ball_sync;
  logic [2:0]       r_team_sync;
  logic [1:0]       r_prime_cnt;
  logic             r_ball_ack;
  logic             r_lfsr_step;
  logic [RUN_W-1:0] r_runs;
  logic [3:0]       r_wickets;
  logic [2:0]       r_balls;
  logic [4:0]       r_overs;
  logic [RUN_W:0]   r_target;
  logic             r_winner;
  logic             r_tie;

  logic             w_sync_ready;
  logic             w_ball_rise;
  logic             w_team_rise;
  logic             w_ball_live;
  logic [2:0]       w_run_inc;
  logic             w_is_wkt;
  logic             w_is_legal;
  logic [RUN_W:0]   w_runs_sum;
  logic [RUN_W-1:0] w_runs_next;
  logic             w_over_done;
  logic [2:0]       w_balls_next;
  logic [4:0]       w_overs_next;
  logic [3:0]       w_wkts_next;
  logic             w_innings_end;
  logic             w_chase_won;
  logic             w_scores_level;

  // Edges are suppressed until the third flop holds a post-reset sample, so a
  // switch already high at reset release is not seen as a press.
  assign w_sync_ready = (r_prime_cnt == 2'd3);
  assign w_ball_rise  = w_sync_ready & r_ball_sync[1] & ~r_ball_sync[2];
  assign w_team_rise  = w_sync_ready & r_team_sync[1] & ~r_team_sync[2];
  assign w_ball_live  = w_ball_rise & ((r_state == ST_INN1) || (r_state == ST_INN2));

  always_comb begin
    w_run_inc  = 3'd0;
    w_is_wkt   = 1'b0;
    w_is_legal = 1'b1;
    case (lfsr_out)
      4'd0, 4'd1, 4'd2:  w_run_inc = 3'd0;
      4'd3, 4'd4, 4'd5:  w_run_inc = 3'd1;
      4'd6, 4'd7:        w_run_inc = 3'd2;
      4'd8:              w_run_inc = 3'd3;
      4'd9, 4'd10:       w_run_inc = 3'd4;
      4'd11:             w_run_inc = 3'd6;
      4'd12, 4'd13:      w_is_wkt  = 1'b1;
      4'd14: begin
        w_run_inc  = 3'd1;
        w_is_legal = 1'b0;
      end
      default:           w_run_inc = 3'd0;
    endcase
  end

  assign w_runs_sum   = {1'b0, r_runs} + (RUN_W+1)'(w_run_inc);
  assign w_runs_next  = w_runs_sum[RUN_W] ? '1 : w_runs_sum[RUN_W-1:0];
  assign w_over_done  = w_is_legal && (r_balls == LP_LAST_BALL);
  assign w_balls_next = !w_is_legal ? r_balls : (w_over_done ? '0 : r_balls + 3'd1);
  assign w_overs_next = w_over_done ? r_overs + 5'd1 : r_overs;
  assign w_wkts_next  = r_wickets + {3'd0, w_is_wkt};

  assign w_innings_end  = (w_wkts_next == LP_WICKETS) || (w_overs_next == LP_OVERS);
  assign w_chase_won    = ({1'b0, w_runs_next} >= r_target);
  assign w_scores_level = (({1'b0, w_runs_next} + 1'b1) == r_target);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_INN1;
      r_ball_sync <= '0;
      r_team_sync <= '0;
      r_prime_cnt <= '0;
      r_ball_ack  <= 1'b0;
      r_lfsr_step <= 1'b0;
      r_runs      <= '0;
      r_wickets   <= '0;
      r_balls     <= '0;
      r_overs     <= '0;
      r_target    <= '0;
      r_winner    <= 1'b0;
      r_tie       <= 1'b0;
    end else begin
      r_ball_sync <= {r_ball_sync[1:0], ball_sw};
      r_team_sync <= {r_team_sync[1:0], team_switch};
      if (!w_sync_ready) begin
        r_prime_cnt <= r_prime_cnt + 2'd1;
      end
      r_ball_ack  <= w_ball_live;
      r_lfsr_step <= r_ball_ack;

      if (w_ball_live) begin
        r_runs    <= w_runs_next;
        r_wickets <= w_wkts_next;
        r_balls   <= w_balls_next;
        r_overs   <= w_overs_next;
      end

      case (r_state)
        ST_INN1: begin
          if (w_ball_live && w_innings_end) begin
            r_state  <= ST_BREAK;
            r_target <= {1'b0, w_runs_next} + 1'b1;
          end
        end
        ST_BREAK: begin
          if (w_team_rise) begin
            r_state   <= ST_INN2;
            r_runs    <= '0;
            r_wickets <= '0;
            r_balls   <= '0;
            r_overs   <= '0;
          end
        end
        ST_INN2: begin
          // Reaching the target wins even on the ball that also ends the innings.
          if (w_ball_live && w_chase_won) begin
            r_state  <= ST_DONE;
            r_winner <= 1'b1;
          end else if (w_ball_live && w_innings_end) begin
            r_state  <= ST_DONE;
            r_winner <= 1'b0;
            r_tie    <= w_scores_level;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign lfsr_step   = r_lfsr_step;
  assign ball_ack    = r_ball_ack;
  assign runs        = r_runs;
  assign wickets     = r_wickets;
  assign balls       = r_balls;
  assign overs       = r_overs;
  assign target      = r_target;
  assign innings     = (r_state == ST_INN2) || (r_state == ST_DONE);
  assign inning_over = (r_state == ST_BREAK);
  assign game_over   = (r_state == ST_DONE);
  assign winner      = r_winner;
  assign tie         = r_tie;

endmodule
